user_glyph_fetcher: RTL and testbench

OBI manager that turns an ASCII character request into a stream of glyph pixel columns by sequencing byte reads from the user-domain font ROM.
- Font layout: 95 glyphs (ASCII 32..126), 12 bytes per glyph, organised as 6 columns × 2 bytes (hi, lo). Each 16-bit column uses bits [15:4] as 12 pixel rows.
- Sits between a text/display engine (character in, column stream out) and the user-domain OBI crossbar port that reaches the font ROM.
- One character is in flight at a time. Each column is emitted once both of its bytes have returned.

---
 rtl/user_glyph_fetcher.sv | 206 ++++++++++++++++++++
 tb/tb_user_glyph_fetcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_glyph_fetcher.sv
// Glyph column fetcher: turns one ASCII code into six 16-bit pixel columns by
// reading the font ROM one byte at a time over an OBI manager port.
package user_glyph_fetcher_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

module user_glyph_fetcher
  import user_glyph_fetcher_pkg::*;
#(
  parameter logic [31:0] ROM_BASE_ADDR = 32'h2000_1000,
  parameter int unsigned FIRST_CHAR    = 32,
  parameter int unsigned LAST_CHAR     = 126,
  parameter int unsigned SUBST_CHAR    = 63
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         char_valid_i,
  output logic         char_ready_o,
  input  logic [7:0]   char_code_i,
  output logic         col_valid_o,
  input  logic         col_ready_i,
  output logic [15:0]  col_data_o,
  output logic [2:0]   col_idx_o,
  output logic         col_last_o,
  output logic         col_err_o,
  output logic         busy_o,
  output mgr_obi_req_t obi_req_o,
  input  mgr_obi_rsp_t obi_rsp_i
);

  localparam logic [7:0] FIRST_CODE = 8'(FIRST_CHAR);
  localparam logic [7:0] LAST_CODE  = 8'(LAST_CHAR);
  localparam logic [7:0] SUBST_CODE = 8'(SUBST_CHAR);
  localparam logic [2:0] LAST_COL   = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, RSP, EMIT} state_t;

  state_t      state_reg;
  logic [10:0] base_reg;
  logic [2:0]  col_reg;
  logic        b_reg;
  logic [7:0]  hi_reg;
  logic [7:0]  lo_reg;
  logic        err_reg;
  logic        req_reg;
  logic [31:0] addr_reg;
  logic        col_valid_reg;
  logic        col_last_reg;
  logic        char_ready_reg;
  logic        busy_reg;

  // Out-of-range codes are drawn as the substitute glyph.
  function automatic logic [10:0] glyph_base(input logic [7:0] code);
    logic [7:0] eff;
    eff = (code >= FIRST_CODE && code <= LAST_CODE) ? code : SUBST_CODE;
    return 11'(eff - FIRST_CODE) * 11'd12;
  endfunction

  // {col, b} is exactly 2*col + b.
  function automatic logic [31:0] byte_addr(input logic [10:0] base,
                                            input logic [2:0] col,
                                            input logic b);
    return ROM_BASE_ADDR + 32'(base) + 32'({col, b});
  endfunction

  logic [10:0] accept_base;
  logic [7:0]  rsp_byte;
  logic [2:0]  col_inc;

  assign accept_base = glyph_base(char_code_i);
  assign rsp_byte    = obi_rsp_i.r.err ? 8'h00 : obi_rsp_i.r.rdata[7:0];
  assign col_inc     = col_reg + 3'd1;

  logic unused_rsp;
  assign unused_rsp = ^{obi_rsp_i.r.rdata[31:8], obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      col_reg        <= '0;
      b_reg          <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      err_reg        <= 1'b0;
      req_reg        <= 1'b0;
      addr_reg       <= '0;
      col_valid_reg  <= 1'b0;
      col_last_reg   <= 1'b0;
      char_ready_reg <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (char_valid_i && char_ready_reg) begin
            base_reg       <= accept_base;
            col_reg        <= '0;
            b_reg          <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            err_reg        <= 1'b0;
            addr_reg       <= byte_addr(accept_base, 3'd0, 1'b0);
            req_reg        <= 1'b1;
            char_ready_reg <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= REQ;
          end
        end

        REQ: begin
          if (obi_rsp_i.gnt) begin
            req_reg   <= 1'b0;
            state_reg <= RSP;
          end
        end

        RSP: begin
          // Only one transaction is ever outstanding, so any rvalid here is ours.
          if (obi_rsp_i.rvalid) begin
            err_reg <= err_reg | obi_rsp_i.r.err;
            if (!b_reg) begin
              hi_reg    <= rsp_byte;
              b_reg     <= 1'b1;
              addr_reg  <= byte_addr(base_reg, col_reg, 1'b1);
              req_reg   <= 1'b1;
              state_reg <= REQ;
            end else begin
              lo_reg        <= rsp_byte;
              col_valid_reg <= 1'b1;
              col_last_reg  <= (col_reg == LAST_COL);
              state_reg     <= EMIT;
            end
          end
        end

        EMIT: begin
          if (col_ready_i) begin
            col_valid_reg <= 1'b0;
            col_last_reg  <= 1'b0;
            if (col_reg == LAST_COL) begin
              char_ready_reg <= 1'b1;
              busy_reg       <= 1'b0;
              state_reg      <= IDLE;
            end else begin
              col_reg   <= col_inc;
              b_reg     <= 1'b0;
              err_reg   <= 1'b0;
              addr_reg  <= byte_addr(base_reg, col_inc, 1'b0);
              req_reg   <= 1'b1;
              state_reg <= REQ;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign char_ready_o = char_ready_reg;
  assign busy_o       = busy_reg;
  assign col_valid_o  = col_valid_reg;
  assign col_data_o   = {hi_reg, lo_reg};
  assign col_idx_o    = col_reg;
  assign col_last_o   = col_last_reg;
  assign col_err_o    = err_reg;

  always_comb begin
    obi_req_o              = '0;
    obi_req_o.req          = req_reg;
    obi_req_o.a.addr       = addr_reg;
    obi_req_o.a.we         = 1'b0;
    obi_req_o.a.be         = 4'b0001;
    obi_req_o.a.wdata      = '0;
    obi_req_o.a.aid        = 1'b0;
    obi_req_o.a.a_optional = 1'b0;
  end

endmodule

// File: tb/tb_user_glyph_fetcher.sv
// Bench for user_glyph_fetcher: font ROM bus model, directed character table
// and hand-written reset-during-fetch sequence.
module tb_user_glyph_fetcher;
  import user_glyph_fetcher_pkg::*;

  logic         clk;
  logic         rst_ni;
  logic         char_valid;
  logic         char_ready;
  logic [7:0]   char_code;
  logic         col_valid;
  logic         col_ready;
  logic [15:0]  col_data;
  logic [2:0]   col_idx;
  logic         col_last;
  logic         col_err;
  logic         busy;
  mgr_obi_req_t obi_req;
  mgr_obi_rsp_t obi_rsp;

  user_glyph_fetcher dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .char_valid_i (char_valid),
    .char_ready_o (char_ready),
    .char_code_i  (char_code),
    .col_valid_o  (col_valid),
    .col_ready_i  (col_ready),
    .col_data_o   (col_data),
    .col_idx_o    (col_idx),
    .col_last_o   (col_last),
    .col_err_o    (col_err),
    .busy_o       (busy),
    .obi_req_o    (obi_req),
    .obi_rsp_i    (obi_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Font ROM contents and bus model knobs.
  logic [7:0]  rom [0:1139];
  int          gnt_wait = 0;
  logic [31:0] err_addr = 32'h0;
  int          stale_req = 0;
  int          stale_done = 0;
  int          proto_viol = 0;
  logic [31:0] addr_log [$];

  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          stall_cnt = 0;
  logic [31:0] stall_addr = 32'h0;
  logic        granted_prev = 1'b0;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h2000_1000;
    if (a >= 32'h2000_1000 && off < 32'd1140) return rom[off];
    return 8'h00;
  endfunction

  initial obi_rsp = '0;

  // gnt/rvalid are updated on the falling edge; rvalid follows a grant by one cycle.
  always @(negedge clk) begin
    obi_rsp = '0;
    if (pend) begin
      obi_rsp.rvalid  = 1'b1;
      obi_rsp.r.err   = (pend_addr == err_addr);
      obi_rsp.r.rdata = {24'hABCDEF, (pend_addr == err_addr) ? 8'hA5 : rom_byte(pend_addr)};
      pend = 1'b0;
    end else if (stale_done < stale_req) begin
      obi_rsp.rvalid  = 1'b1;
      obi_rsp.r.rdata = 32'h0000_00FF;
      stale_done++;
    end
    if (obi_req.req) begin
      if (granted_prev) proto_viol++;
      if (stall_cnt > 0 && obi_req.a.addr != stall_addr) proto_viol++;
      if (obi_req.a.we || obi_req.a.be != 4'b0001 || obi_req.a.wdata != 32'h0) proto_viol++;
      if (stall_cnt < gnt_wait) begin
        if (stall_cnt == 0) stall_addr = obi_req.a.addr;
        stall_cnt++;
      end else begin
        obi_rsp.gnt = 1'b1;
        stall_cnt   = 0;
        pend        = 1'b1;
        pend_addr   = obi_req.a.addr;
        addr_log.push_back(obi_req.a.addr);
      end
    end else if (stall_cnt > 0) begin
      proto_viol++;
      stall_cnt = 0;
    end
    granted_prev = obi_rsp.gnt;
  end

  typedef struct {
    logic [7:0]        code;
    logic [31:0]       base;
    logic [0:5][15:0]  cols;
    logic [5:0]        errs;
    int                gw;
    logic [31:0]       ea;
    int                ready_col;
    int                ready_stall;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] code, input logic [31:0] base,
                              input logic [0:5][15:0] cols, input logic [5:0] errs,
                              input int gw, input logic [31:0] ea,
                              input int rc, input int rs);
    vec_t v;
    v.code = code; v.base = base; v.cols = cols; v.errs = errs;
    v.gw = gw; v.ea = ea; v.ready_col = rc; v.ready_stall = rs;
    return v;
  endfunction

  task automatic set_glyph(input logic [7:0] code, input logic [0:5][15:0] cols);
    int base;
    base = (int'(code) - 32) * 12;
    for (int c = 0; c < 6; c++) begin
      rom[base + 2*c]     = cols[c][15:8];
      rom[base + 2*c + 1] = cols[c][7:0];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char_ready"}, 32'(char_ready), 32'd1);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_col_valid"},  32'(col_valid),  32'd0);
    check({tag, "_col_data"},   32'(col_data),   32'd0);
    check({tag, "_col_idx"},    32'(col_idx),    32'd0);
    check({tag, "_col_last"},   32'(col_last),   32'd0);
    check({tag, "_col_err"},    32'(col_err),    32'd0);
    check({tag, "_req"},        32'(obi_req.req), 32'd0);
  endtask

  task automatic run_char(input vec_t v);
    int cyc;
    int viol0;
    addr_log.delete();
    gnt_wait = v.gw;
    err_addr = v.ea;
    viol0    = proto_viol;
    check("char_ready_idle", 32'(char_ready), 32'd1);
    char_valid = 1'b1;
    char_code  = v.code;
    @(posedge clk); #1;
    char_valid = 1'b0;
    char_code  = 8'h00;
    for (int i = 0; i < 6; i++) begin
      cyc = 0;
      while (!col_valid && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (!col_valid) begin
        tests++;
        failed++;
        $display("FAIL col_timeout: column %0d not valid after %0d cycles, required within 200", i, cyc);
        return;
      end
      if (i == 0 && v.gw == 0) check("first_col_latency", 32'(cyc), 32'd4);
      check("col_data", 32'(col_data), 32'(v.cols[i]));
      check("col_idx",  32'(col_idx),  32'(i));
      check("col_last", 32'(col_last), (i == 5) ? 32'd1 : 32'd0);
      check("col_err",  32'(col_err),  32'(v.errs[i]));
      if (i == v.ready_col) begin
        col_ready = 1'b0;
        repeat (v.ready_stall) begin
          @(posedge clk); #1;
          check("stall_valid", 32'(col_valid), 32'd1);
          check("stall_data",  32'(col_data),  32'(v.cols[i]));
          check("stall_idx",   32'(col_idx),   32'(i));
          check("stall_no_req", 32'(obi_req.req), 32'd0);
        end
        col_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("busy_after", 32'(busy), 32'd0);
    check("ready_after", 32'(char_ready), 32'd1);
    check("req_count", 32'(addr_log.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      if (k < addr_log.size()) check("req_addr", addr_log[k], v.base + 32'(k));
    check("bus_protocol", 32'(proto_viol - viol0), 32'd0);
    $display("[TB] char 0x%02h: 6 columns, %0d requests from 0x%08h", v.code, addr_log.size(), v.base);
  endtask

  vec_t vecs [0:5];
  vec_t zero_vec;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish within 2 ms");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int i = 0; i < 1140; i++) rom[i] = 8'h00;
    set_glyph(8'h41, {16'h0040, 16'h07C0, 16'h3900, 16'h0F00, 16'h01C0, 16'h0040});
    set_glyph(8'h3F, {16'h1800, 16'h2000, 16'h2340, 16'h2400, 16'h1800, 16'h0000});
    set_glyph(8'h7E, {16'h2000, 16'h4000, 16'h2000, 16'h1000, 16'h2000, 16'h4000});
    set_glyph(8'h31, {16'h0000, 16'h1000, 16'h3FC0, 16'h0040, 16'h0000, 16'h0000});
    set_glyph(8'h30, {16'h1F80, 16'h2040, 16'h2040, 16'h2040, 16'h1F80, 16'h0000});
    set_glyph(8'h42, {16'h3FC0, 16'h2240, 16'h2240, 16'h1D80, 16'h0000, 16'h0000});

    vecs[0] = mk(8'h41, 32'h2000_118C, {16'h0040, 16'h07C0, 16'h3900, 16'h0F00, 16'h01C0, 16'h0040}, 6'b0, 0, 32'h0, 9, 0);
    vecs[1] = mk(8'h0A, 32'h2000_1174, {16'h1800, 16'h2000, 16'h2340, 16'h2400, 16'h1800, 16'h0000}, 6'b0, 0, 32'h0, 9, 0);
    vecs[2] = mk(8'h7F, 32'h2000_1174, {16'h1800, 16'h2000, 16'h2340, 16'h2400, 16'h1800, 16'h0000}, 6'b0, 0, 32'h0, 9, 0);
    vecs[3] = mk(8'h20, 32'h2000_1000, {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 6'b0, 3, 32'h0, 9, 0);
    vecs[4] = mk(8'h7E, 32'h2000_1468, {16'h2000, 16'h4000, 16'h2000, 16'h1000, 16'h2000, 16'h4000}, 6'b0, 0, 32'h0, 2, 5);
    vecs[5] = mk(8'h31, 32'h2000_10CC, {16'h0000, 16'h1000, 16'h3FC0, 16'h0040, 16'h0000, 16'h0000}, 6'b000010, 0, 32'h2000_10CF, 9, 0);
    zero_vec = mk(8'h30, 32'h2000_10C0, {16'h1F80, 16'h2040, 16'h2040, 16'h2040, 16'h1F80, 16'h0000}, 6'b0, 0, 32'h0, 9, 0);

    rst_ni     = 1'b0;
    char_valid = 1'b0;
    char_code  = 8'h00;
    col_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++) run_char(vecs[n]);

    // Reset while the hi byte of column 3 of 'B' is outstanding.
    addr_log.delete();
    gnt_wait = 0;
    err_addr = 32'h0;
    char_valid = 1'b1;
    char_code  = 8'h42;
    @(posedge clk); #1;
    char_valid = 1'b0;
    cyc = 0;
    while (addr_log.size() < 7 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midreset_reqs_before", 32'(addr_log.size()), 32'd7);
    check("midreset_busy_before", 32'(busy), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    stale_req++;
    repeat (3) @(posedge clk);
    #1;
    check("stale_busy", 32'(busy), 32'd0);
    check("stale_col_valid", 32'(col_valid), 32'd0);
    check("stale_char_ready", 32'(char_ready), 32'd1);
    $display("[TB] reset during fetch of 0x42 after %0d requests", addr_log.size());
    run_char(zero_vec);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
